// File: rtl/mul_seq_ctrl_if.sv
// Handshake and operand bundle between the EX stage and the iterative multiplier.
// The pipeline side is the master; the multiplier sequencer is the slave.
interface mul_seq_ctrl_if;
    logic        mul_start;
    logic [2:0]  mul_funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        mul_finish;
    logic        mul_busy;
    logic [31:0] mul_result;

    modport master (
        output mul_start, mul_funct3, rs1_data, rs2_data,
        input  mul_finish, mul_busy, mul_result
    );

    modport slave (
        input  mul_start, mul_funct3, rs1_data, rs2_data,
        output mul_finish, mul_busy, mul_result
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU in the EX stage.
// Holds mul_finish low to stall the pipeline until the selected product half is ready.
module mul_seq_ctrl #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    mul_seq_ctrl_if.slave bus
);

    localparam int         ITER = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] LAST = 6'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        finish;
    logic        busy;

    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [5:0]  cnt;
    logic        neg;
    logic [1:0]  f3_q;
    logic [31:0] result;

    logic        op_ok;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] partial;
    logic [63:0] acc_sum;
    logic [63:0] prod_final;

    assign op_ok = bus.mul_start && !bus.mul_funct3[2];

    // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
    assign a_neg = bus.rs1_data[31] &&
                   (bus.mul_funct3[1:0] == 2'b01 || bus.mul_funct3[1:0] == 2'b10);
    assign b_neg = bus.rs2_data[31] && (bus.mul_funct3[1:0] == 2'b01);
    assign a_mag = a_neg ? (32'd0 - bus.rs1_data) : bus.rs1_data;
    assign b_mag = b_neg ? (32'd0 - bus.rs2_data) : bus.rs2_data;

    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    assign acc_sum    = acc + partial;
    assign prod_final = neg ? (64'd0 - acc_sum) : acc_sum;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latch).
    always_comb begin
        state_next = state;
        finish     = 1'b1;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (op_ok) begin
                    state_next = BUSY;
                    finish     = 1'b0;
                end
            end
            BUSY: begin
                busy   = 1'b1;
                finish = 1'b0;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            finish = 1'b1;
        end
    end

    // NOTE: datapath registers are reset too, because mul_result is visible to
    // the pipeline and must read 0 after reset rather than a stale product.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            f3_q   <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_ok) begin
                        acc    <= '0;
                        mcand  <= {32'd0, a_mag};
                        mplier <= b_mag;
                        cnt    <= '0;
                        neg    <= a_neg ^ b_neg;
                        f3_q   <= bus.mul_funct3[1:0];
                    end
                end
                BUSY: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + 6'd1;
                    // Final iteration: register the signed product half seen in DONE.
                    if (cnt == LAST) begin
                        result <= (f3_q == 2'b00) ? prod_final[31:0] : prod_final[63:32];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mul_finish = finish;
    assign bus.mul_busy   = busy;
    assign bus.mul_result = result;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: stimulus queues expected products and DONE
// cycles, per-instance monitors pop and compare on each DONE pulse.
module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_seq_ctrl_if bus1();
    mul_seq_ctrl_if bus4();

    mul_seq_ctrl #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mul_seq_ctrl #(.BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done1    = 0;
    int done4    = 0;
    logic pb1    = 1'b0;
    logic pb4    = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // DONE is the cycle where finish is high right after a BUSY cycle, outside reset.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus1.mul_finish && pb1) begin
            done1++;
            check("sb1_pending", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("dut1_result", 64'(bus1.mul_result), 64'(e.res));
                check("dut1_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        pb1 = bus1.mul_busy && !rst;
        if (!rst && bus4.mul_finish && pb4) begin
            done4++;
            check("sb4_pending", 64'(q4.size() != 0), 64'd1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                check("dut4_result", 64'(bus4.mul_result), 64'(e.res));
                check("dut4_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        pb4 = bus4.mul_busy && !rst;
    end

    task automatic drive1(input logic s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus1.mul_start  = s;
        bus1.mul_funct3 = f;
        bus1.rs1_data   = a;
        bus1.rs2_data   = b;
    endtask

    // One multiply on the 1-bit instance; start held until the DONE edge.
    task automatic run1(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        int n;
        int lows;
        @(posedge clk); #1;
        drive1(1'b1, f, a, b);
        q1.push_back('{exp, cyc + 33});
        n    = done1;
        lows = 0;
        for (int i = 0; i < 60 && done1 == n; i++) begin
            @(negedge clk); #1;
            if (!bus1.mul_finish && done1 == n) lows++;
        end
        check({name, "_done"}, 64'(done1), 64'(n + 1));
        check({name, "_stall_cycles"}, 64'(lows), 64'd33);
        @(posedge clk); #1;
        bus1.mul_start = 1'b0;
        @(negedge clk);
        check({name, "_idle_after"}, {62'd0, bus1.mul_busy, bus1.mul_finish}, 64'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        int lows;
        rst = 1'b1;
        drive1(1'b0, 3'b000, 32'd0, 32'd0);
        bus4.mul_start  = 1'b0;
        bus4.mul_funct3 = 3'b000;
        bus4.rs1_data   = 32'd0;
        bus4.rs2_data   = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_finish_high", 64'(bus1.mul_finish), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(bus1.mul_busy), 64'd0);
        check("reset_result", 64'(bus1.mul_result), 64'd0);
        check("reset_finish", 64'(bus1.mul_finish), 64'd1);

        // Directed products
        run1("mul_7x6",     3'b000, 32'd7,        32'd6,        32'h0000002A);
        run1("mulh_min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
        run1("mul_ones",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run1("mulh_ones",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run1("mulhsu_ones", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run1("mulhu_ones",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run1("mul_zero",    3'b000, 32'h12345678, 32'h00000000, 32'h00000000);
        run1("mulhu_pre",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);

        // Back-to-back: start stays high, operands switch after the first DONE
        @(posedge clk); #1;
        drive1(1'b1, 3'b000, 32'd3, 32'd4);
        q1.push_back('{32'd12, cyc + 33});
        q1.push_back('{32'd81, cyc + 67});
        n = done1;
        for (int i = 0; i < 50 && done1 == n; i++) begin
            @(negedge clk); #1;
        end
        check("b2b_first_done", 64'(done1), 64'(n + 1));
        @(posedge clk); #1;
        bus1.rs1_data = 32'd9;
        bus1.rs2_data = 32'd9;
        for (int i = 0; i < 50 && done1 == n + 1; i++) begin
            @(negedge clk); #1;
        end
        check("b2b_second_done", 64'(done1), 64'(n + 2));
        @(posedge clk); #1;
        bus1.mul_start = 1'b0;
        repeat (40) @(negedge clk);
        check("b2b_no_third", 64'(done1), 64'(n + 2));
        check("b2b_idle_busy", 64'(bus1.mul_busy), 64'd0);

        // funct3[2] set never starts
        @(posedge clk); #1;
        drive1(1'b1, 3'b100, 32'd5, 32'd5);
        n = done1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("f3_1xx_finish", 64'(bus1.mul_finish), 64'd1);
            check("f3_1xx_busy", 64'(bus1.mul_busy), 64'd0);
        end
        check("f3_1xx_no_done", 64'(done1), 64'(n));
        @(posedge clk); #1;
        bus1.mul_start = 1'b0;

        // Reset at BUSY cycle 10: no DONE, result cleared, then a clean multiply
        @(posedge clk); #1;
        drive1(1'b1, 3'b000, 32'd9, 32'd9);
        n = done1;
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(bus1.mul_busy), 64'd1);
        rst = 1'b1;
        bus1.mul_start = 1'b0;
        @(negedge clk);
        check("mid_rst_finish", 64'(bus1.mul_finish), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 64'(bus1.mul_busy), 64'd0);
        check("post_rst_finish", 64'(bus1.mul_finish), 64'd1);
        check("post_rst_result", 64'(bus1.mul_result), 64'd0);
        repeat (40) @(negedge clk);
        check("post_rst_no_done", 64'(done1), 64'(n));
        run1("mul_3x5", 3'b000, 32'd3, 32'd5, 32'h0000000F);

        // 4 bits per cycle: DONE at T+9
        @(posedge clk); #1;
        bus4.mul_start  = 1'b1;
        bus4.mul_funct3 = 3'b011;
        bus4.rs1_data   = 32'h12345678;
        bus4.rs2_data   = 32'h9ABCDEF0;
        q4.push_back('{32'h0B00EA4E, cyc + 9});
        n    = done4;
        lows = 0;
        for (int i = 0; i < 30 && done4 == n; i++) begin
            @(negedge clk); #1;
            if (!bus4.mul_finish && done4 == n) lows++;
        end
        check("bpc4_done", 64'(done4), 64'(n + 1));
        check("bpc4_stall_cycles", 64'(lows), 64'd9);
        @(posedge clk); #1;
        bus4.mul_start = 1'b0;
        repeat (3) @(negedge clk);

        check("sb1_empty", 64'(q1.size()), 64'd0);
        check("sb4_empty", 64'(q4.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Iterative multiplier sequencer for the EX stage of the 5-stage RV32 pipeline.
- Accepts an M-extension multiply (MUL/MULH/MULHSU/MULHU) from the ID/EX register and runs a shift-add multiply over several cycles.
- Drives mul_finish low to freeze the EX/MEM register (and upstream stages) until the product is ready.
- mul_result feeds the EX result mux in place of the ALU output.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration. Legal values 1, 2, 4. ITER = 32/BITS_PER_CYCLE.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- mul_start  input  1  ID/EX holds a valid multiply; held high by the stall until the instruction leaves EX.
- mul_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx never starts an operation.
- rs1_data  input  32  forwarded multiplicand.
- rs2_data  input  32  forwarded multiplier.
- mul_finish  output  1  1 = EX may advance; 0 = stall.
- mul_busy  output  1  high in BUSY state.
- mul_result  output  32  selected half of the product.

Behaviour:
- Reset values: state IDLE, product/operand registers 0, mul_result 0, mul_busy 0. mul_finish is 1 while rst is high.
- States: IDLE, BUSY, DONE.
- IDLE:
  - mul_start=1 and funct3[2]=0: latch operands and funct3, counter=0, go to BUSY.
  - mul_finish is combinationally 0 in this cycle.
  - Otherwise stay in IDLE with mul_finish=1.
- Operand conditioning at latch:
  - rs1 is signed for MULH/MULHSU; rs2 is signed for MULH only.
  - Each signed operand is stored as its 32-bit magnitude (0x80000000 stays 0x80000000).
  - neg flag = XOR of the sign bits of the signed operands.
- BUSY:
  - Each cycle, add (multiplicand × next BITS_PER_CYCLE multiplier bits) into a 64-bit accumulator, then shift.
  - Counter increments. After ITER cycles go to DONE.
  - mul_finish=0, mul_busy=1.
- DONE:
  - Product is 64-bit; if neg, negate it (two's complement, 64 bits).
  - mul_result = low 32 bits for MUL, high 32 bits otherwise. Value is registered on entry to DONE.
  - mul_finish=1 for exactly this cycle. The pipeline advances on this edge.
  - Next state is always IDLE. mul_start is ignored in DONE (same instruction, no restart).
- Latency: start seen in IDLE at cycle T → BUSY T+1..T+ITER → DONE at T+ITER+1. Total stall = ITER+1 cycles (33 for BITS_PER_CYCLE=1).
- mul_result holds its value until the next DONE or rst.
- Back-to-back multiplies: after DONE, a new mul_start in the following IDLE cycle starts a new operation immediately (stalls again that cycle).
- Reset mid-operation: rst in any state → IDLE next edge, mul_result cleared, no DONE pulse.
- Operand changes while BUSY (forwarding updates) are ignored; only values latched in IDLE are used.
- mul_start low while BUSY (not expected) does not abort the operation.

Test Plan:
- MUL 7×6, BITS_PER_CYCLE=1, start at T → mul_finish 0 for T..T+32, 1 at T+33; mul_result=0x0000002A at T+33; state IDLE at T+34.
- MULH 0x80000000×0x80000000 → 0x40000000. MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001. MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFF. MULHU same operands → 0xFFFFFFFE. MUL with rs2=0 → 0x00000000.
- Two multiplies back-to-back with mul_start continuously high → two separate DONE pulses 34 cycles apart, no third start. funct3=100 with mul_start=1 → mul_finish stays 1, state stays IDLE.
- rst asserted at BUSY cycle 10 → next cycle IDLE, mul_finish=1, mul_result=0. A following MUL 3×5 completes normally with result 0x0000000F.
- BITS_PER_CYCLE=4: MULHU 0x12345678×0x9ABCDEF0 → DONE at T+9, mul_result=0x0B00EA4E.
